// File: rtl/spi_adc_slave.sv
// spi_adc_slave: SPI mode-0 responder emulating a 2-channel ADC.
// All SPI pins are oversampled on clk_i. An 8-bit command selects the channel
// (bit 7 = start bit, bit 6 = channel). The selected sample is frozen when the
// command completes and is shifted out MSB-first on miso_o on dclk falls.
module spi_adc_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DWIDTH      = 12,
  parameter int CWIDTH      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_i,
  input  logic              dclk_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DWIDTH-1:0] ch0_i,
  input  logic [DWIDTH-1:0] ch1_i,
  output logic [CWIDTH-1:0] cmd_o,
  output logic              cmd_valid_o,
  output logic              frame_done_o,
  output logic              abort_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int CCW = $clog2(CWIDTH);
  localparam int DCW = $clog2(DWIDTH + 1);
  localparam logic [CCW-1:0] CMD_LAST  = CCW'(CWIDTH - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DWIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_CS = 2'd3
  } state_e;

  // Synchronizer chains and edge-detect history
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] dclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_prev_q;
  logic                   dclk_prev_q;

  // Frame state
  state_e                 state_q;
  logic [CCW-1:0]         cmd_cnt_q;
  logic [DCW-1:0]         data_cnt_q;
  logic [CWIDTH-1:0]      cmd_shift_q;
  logic [DWIDTH-1:0]      snapshot_q;

  // Registered outputs
  logic                   miso_q;
  logic [CWIDTH-1:0]      cmd_q;
  logic                   cmd_valid_q;
  logic                   frame_done_q;
  logic                   abort_q;
  logic                   err_q;
  logic                   busy_q;

  // Decoded synchronized levels and edges
  logic                   cs_s;
  logic                   dclk_s;
  logic                   mosi_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;
  logic                   dclk_rise_s;
  logic                   dclk_fall_s;
  logic [CWIDTH-1:0]      new_cmd_s;

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign dclk_s      = dclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;
  assign dclk_rise_s = dclk_s & ~dclk_prev_q;
  assign dclk_fall_s = ~dclk_s & dclk_prev_q;
  // Command as it will look once the bit currently on mosi is shifted in
  assign new_cmd_s   = {cmd_shift_q[CWIDTH-2:0], mosi_s};

  // Oversample SPI pins; cs resets to its idle-high level so release from reset is quiet
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      dclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      cs_prev_q   <= 1'b1;
      dclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], dclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      cs_prev_q   <= cs_s;
      dclk_prev_q <= dclk_s;
    end
  end

  // Frame FSM: command capture, sample snapshot, MSB-first shift-out, end-of-frame pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_cnt_q    <= '0;
      data_cnt_q   <= '0;
      cmd_shift_q  <= '0;
      snapshot_q   <= '0;
      miso_q       <= 1'b0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall_s) begin
            state_q     <= ST_CMD;
            busy_q      <= 1'b1;
            cmd_cnt_q   <= '0;
            cmd_shift_q <= '0;
          end
        end
        ST_CMD: begin
          // cs rise takes priority over any dclk edge in the same cycle
          if (cs_rise_s) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (dclk_rise_s) begin
            cmd_shift_q <= new_cmd_s;
            if (cmd_cnt_q == CMD_LAST) begin
              cmd_q       <= new_cmd_s;
              cmd_valid_q <= 1'b1;
              err_q       <= ~new_cmd_s[CWIDTH-1];
              if (!new_cmd_s[CWIDTH-1]) begin
                snapshot_q <= '0;
              end else if (new_cmd_s[CWIDTH-2]) begin
                snapshot_q <= ch1_i;
              end else begin
                snapshot_q <= ch0_i;
              end
              data_cnt_q <= '0;
              state_q    <= ST_DATA;
            end else begin
              cmd_cnt_q <= cmd_cnt_q + CCW'(1);
            end
          end
        end
        ST_DATA: begin
          if (cs_rise_s) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (dclk_fall_s && (data_cnt_q != DATA_LAST)) begin
            miso_q     <= snapshot_q[DWIDTH-1];
            snapshot_q <= {snapshot_q[DWIDTH-2:0], 1'b0};
            data_cnt_q <= data_cnt_q + DCW'(1);
          end else if (dclk_rise_s && (data_cnt_q == DATA_LAST)) begin
            // master has sampled the last bit on this rise
            miso_q  <= 1'b0;
            state_q <= ST_WAIT_CS;
          end
        end
        ST_WAIT_CS: begin
          miso_q <= 1'b0;
          if (cs_rise_s) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          miso_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign miso_o       = miso_q;
  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign frame_done_o = frame_done_q;
  assign abort_o      = abort_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;

endmodule
